// File: rtl/ibex_efpga_arbiter.sv
// Round-robin arbiter and sequencer for the shared eFPGA custom-instruction unit.
// One request is accepted at a time. Its operator, operand and delay are latched
// and held on the eFPGA port while the operation is in flight. The unit's ready
// pulse is awaited under a timeout guard. The result, or a timeout error, goes
// back to the owning requester as a one-cycle response pulse.
module ibex_efpga_arbiter #(
    parameter int unsigned NUM_REQ = 2,
    parameter int unsigned TIMEOUT = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NUM_REQ-1:0]    req_i,
    input  logic [2*NUM_REQ-1:0]  req_op_i,
    input  logic [32*NUM_REQ-1:0] req_operand_i,
    input  logic [4*NUM_REQ-1:0]  req_delay_i,
    output logic [NUM_REQ-1:0]    gnt_o,
    output logic [NUM_REQ-1:0]    rsp_valid_o,
    output logic [31:0]           rsp_data_o,
    output logic                  rsp_err_o,
    output logic                  busy_o,
    output logic                  efpga_en_o,
    output logic [1:0]            efpga_op_o,
    output logic [31:0]           efpga_operand_o,
    output logic [3:0]            efpga_delay_o,
    input  logic                  efpga_ready_i,
    input  logic [31:0]           efpga_result_i
);

    localparam int unsigned OW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int unsigned CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_e;

    state_e        state_q, state_d;
    logic [OW-1:0] owner_q, owner_d;
    logic [OW-1:0] last_owner_q, last_owner_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [1:0]    op_q, op_d;
    logic [31:0]   operand_q, operand_d;
    logic [3:0]    delay_q, delay_d;
    logic [31:0]   result_q, result_d;
    logic          err_q, err_d;

    // Per-requester views of the flat request buses.
    logic [NUM_REQ-1:0][1:0]  op_arr;
    logic [NUM_REQ-1:0][31:0] operand_arr;
    logic [NUM_REQ-1:0][3:0]  delay_arr;

    assign op_arr      = req_op_i;
    assign operand_arr = req_operand_i;
    assign delay_arr   = req_delay_i;

    logic          win_vld;
    logic [OW-1:0] win_idx;
    logic [OW:0]   cand;

    // Round-robin pick: the scan runs from the farthest offset down to
    // last_owner+1, so the nearest requester above the last owner wins.
    always_comb begin
        win_vld = 1'b0;
        win_idx = '0;
        cand    = '0;
        for (int i = NUM_REQ; i >= 1; i--) begin
            cand = {1'b0, last_owner_q} + (OW+1)'(i);
            if (cand >= (OW+1)'(NUM_REQ)) begin
                cand = cand - (OW+1)'(NUM_REQ);
            end
            if (req_i[cand[OW-1:0]]) begin
                win_vld = 1'b1;
                win_idx = cand[OW-1:0];
            end
        end
    end

    // Next-state logic for the sequencer and its latched datapath.
    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        last_owner_d = last_owner_q;
        cnt_d        = cnt_q;
        op_d         = op_q;
        operand_d    = operand_q;
        delay_d      = delay_q;
        result_d     = result_q;
        err_d        = err_q;
        unique case (state_q)
            IDLE: begin
                if (win_vld) begin
                    owner_d   = win_idx;
                    op_d      = op_arr[win_idx];
                    operand_d = operand_arr[win_idx];
                    delay_d   = delay_arr[win_idx];
                    state_d   = ISSUE;
                end
            end
            ISSUE: begin
                cnt_d   = '0;
                state_d = WAIT;
            end
            WAIT: begin
                // A ready that lands on the last allowed cycle still wins.
                if (efpga_ready_i) begin
                    result_d = efpga_result_i;
                    err_d    = 1'b0;
                    state_d  = RESP;
                end else if (cnt_q == CNT_MAX) begin
                    result_d = '0;
                    err_d    = 1'b1;
                    state_d  = RESP;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            RESP: begin
                last_owner_d = owner_q;
                state_d      = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            owner_q      <= '0;
            last_owner_q <= OW'(NUM_REQ - 1);
            cnt_q        <= '0;
            op_q         <= '0;
            operand_q    <= '0;
            delay_q      <= '0;
            result_q     <= '0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            last_owner_q <= last_owner_d;
            cnt_q        <= cnt_d;
            op_q         <= op_d;
            operand_q    <= operand_d;
            delay_q      <= delay_d;
            result_q     <= result_d;
            err_q        <= err_d;
        end
    end

    assign gnt_o           = (state_q == ISSUE) ? (NUM_REQ'(1) << owner_q) : '0;
    assign rsp_valid_o     = (state_q == RESP)  ? (NUM_REQ'(1) << owner_q) : '0;
    assign efpga_en_o      = (state_q == ISSUE);
    assign busy_o          = (state_q != IDLE);
    assign rsp_data_o      = result_q;
    assign rsp_err_o       = err_q;
    assign efpga_op_o      = op_q;
    assign efpga_operand_o = operand_q;
    assign efpga_delay_o   = delay_q;

endmodule

// File: tb/tb_ibex_efpga_arbiter.sv
// Scoreboard bench for ibex_efpga_arbiter with a behavioural eFPGA unit model.
module tb_ibex_efpga_arbiter;

    localparam int N  = 2;
    localparam int TO = 32;

    logic            clk = 1'b0;
    logic            rst;
    logic [N-1:0]    req_i;
    logic [2*N-1:0]  req_op_i;
    logic [32*N-1:0] req_operand_i;
    logic [4*N-1:0]  req_delay_i;
    logic [N-1:0]    gnt_o, rsp_valid_o;
    logic [31:0]     rsp_data_o;
    logic            rsp_err_o, busy_o, efpga_en_o;
    logic [1:0]      efpga_op_o;
    logic [31:0]     efpga_operand_o;
    logic [3:0]      efpga_delay_o;
    logic            efpga_ready_i;
    logic [31:0]     efpga_result_i;

    ibex_efpga_arbiter #(.NUM_REQ(N), .TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst), .req_i(req_i), .req_op_i(req_op_i),
        .req_operand_i(req_operand_i), .req_delay_i(req_delay_i),
        .gnt_o(gnt_o), .rsp_valid_o(rsp_valid_o), .rsp_data_o(rsp_data_o),
        .rsp_err_o(rsp_err_o), .busy_o(busy_o), .efpga_en_o(efpga_en_o),
        .efpga_op_o(efpga_op_o), .efpga_operand_o(efpga_operand_o),
        .efpga_delay_o(efpga_delay_o), .efpga_ready_i(efpga_ready_i),
        .efpga_result_i(efpga_result_i)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;
    int cyc   = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Unit-model modes: 0 normal, 1 spurious ready during ISSUE,
    // 2 ready never comes, 3 ready with 0xA5A5A5A5 on the last WAIT cycle.
    int m_mode = 0;

    typedef struct {
        int          owner;
        logic [31:0] data;
        logic        err;
        int          cyc;
    } exp_t;

    exp_t        sb[$];
    exp_t        e;
    int          m_last = N - 1;
    bit          p_vld  = 0;
    int          p_own, p_cyc;
    logic [1:0]  p_op;
    logic [31:0] p_opd;
    logic [3:0]  p_dly;
    int          gnt_cnt = 0;
    int          rsp_cnt = 0;
    int          gnt_log[64];
    bit          busy_chk = 0;

    function automatic int rr(input logic [N-1:0] r, input int last);
        for (int i = 1; i <= N; i++) begin
            if (r[(last + i) % N]) return (last + i) % N;
        end
        return 0;
    endfunction

    // Monitor: predicts grants, pushes expected responses, pops on rsp_valid.
    always @(negedge clk) begin
        if (busy_chk) begin
            chk("busy_after_rsp", busy_o, 0);
            busy_chk = 0;
        end
        if (rst) begin
            sb.delete();
            m_last = N - 1;
            p_vld  = 0;
        end else begin
            if (rsp_valid_o != 0) begin
                if (sb.size() == 0) begin
                    chk("rsp_unexpected", rsp_valid_o, 0);
                end else begin
                    e = sb.pop_front();
                    chk("rsp_valid", rsp_valid_o, 32'(1) << e.owner);
                    chk("rsp_data", rsp_data_o, e.data);
                    chk("rsp_err", rsp_err_o, e.err);
                    chk("rsp_cycle", cyc, e.cyc);
                    m_last = e.owner;
                    rsp_cnt++;
                    busy_chk = 1;
                end
            end
            if (efpga_en_o || gnt_o != 0) chk("en_with_gnt", efpga_en_o, gnt_o != 0);
            if (p_vld && gnt_o == 0) begin
                chk("gnt_missing", gnt_o, 32'(1) << p_own);
                p_vld = 0;
            end
            if (gnt_o != 0) begin
                if (!p_vld) begin
                    chk("gnt_unexpected", gnt_o, 0);
                end else begin
                    chk("gnt", gnt_o, 32'(1) << p_own);
                    chk("gnt_latency", cyc, p_cyc + 1);
                    chk("efpga_op", efpga_op_o, p_op);
                    chk("efpga_operand", efpga_operand_o, p_opd);
                    chk("efpga_delay", efpga_delay_o, p_dly);
                    e.owner = p_own;
                    e.err   = (m_mode == 2);
                    e.data  = (m_mode == 2) ? 32'h0 : (m_mode == 3) ? 32'hA5A5A5A5 : p_opd;
                    e.cyc   = (m_mode >= 2) ? cyc + TO + 1 : cyc + 3 + int'(p_dly);
                    sb.push_back(e);
                    if (gnt_cnt < 64) gnt_log[gnt_cnt] = p_own;
                    gnt_cnt++;
                    p_vld = 0;
                end
            end
            if (!busy_o && req_i != 0) begin
                p_own = rr(req_i, m_last);
                p_cyc = cyc;
                p_op  = req_op_i[2*p_own +: 2];
                p_opd = req_operand_i[32*p_own +: 32];
                p_dly = req_delay_i[4*p_own +: 4];
                p_vld = 1;
            end
        end
    end

    // Behavioural eFPGA unit: ready 2+delay cycles after en, echoing the operand.
    int          md_wait;
    logic [31:0] md_res;
    bit          md_ab;
    always begin
        @(negedge clk);
        if (efpga_en_o && !rst) begin
            md_res  = efpga_operand_o;
            md_ab   = 0;
            md_wait = (m_mode >= 2) ? TO : 2 + int'(efpga_delay_o);
            if (m_mode == 1) begin
                efpga_ready_i  = 1'b1;
                efpga_result_i = 32'hBAD0BAD0;
            end
            for (int i = 0; i < md_wait; i++) begin
                @(negedge clk);
                efpga_ready_i  = 1'b0;
                efpga_result_i = '0;
                if (rst) begin
                    md_ab = 1;
                    break;
                end
            end
            if (!md_ab && m_mode != 2) begin
                efpga_ready_i  = 1'b1;
                efpga_result_i = (m_mode == 3) ? 32'hA5A5A5A5 : md_res;
                @(negedge clk);
                efpga_ready_i  = 1'b0;
                efpga_result_i = '0;
            end
        end
    end

    task automatic set_port(input int k, input logic [1:0] op, input logic [31:0] opd,
                            input logic [3:0] d);
        req_op_i[2*k +: 2]       = op;
        req_operand_i[32*k +: 32] = opd;
        req_delay_i[4*k +: 4]     = d;
    endtask

    task automatic wait_cnt(input string tag, input bit rsp, input int target, input int bound);
        int n = 0;
        while ((rsp ? rsp_cnt : gnt_cnt) < target && n < bound) begin
            @(posedge clk);
            n++;
        end
        chk(tag, (rsp ? rsp_cnt : gnt_cnt) >= target, 1);
        #1;
    endtask

    task automatic single(input int k, input logic [1:0] op, input logic [31:0] opd,
                          input logic [3:0] d, input int mode);
        m_mode = mode;
        set_port(k, op, opd, d);
        req_i[k] = 1'b1;
        wait_cnt("wait_gnt", 0, gnt_cnt + 1, 20);
        req_i[k] = 1'b0;
        wait_cnt("wait_rsp", 1, rsp_cnt + 1, 80);
    endtask

    task automatic pulse_rst();
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    int base, saved;
    int alt_exp[4] = '{0, 1, 0, 1};

    initial begin
        rst = 1'b1;
        req_i = '0; req_op_i = '0; req_operand_i = '0; req_delay_i = '0;
        efpga_ready_i = 1'b0; efpga_result_i = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_gnt", gnt_o, 0);
        chk("rst_rsp_valid", rsp_valid_o, 0);
        chk("rst_rsp_data", rsp_data_o, 0);
        chk("rst_rsp_err", rsp_err_o, 0);
        chk("rst_busy", busy_o, 0);
        chk("rst_en", efpga_en_o, 0);
        @(posedge clk); #1;
        rst = 1'b0;

        // Single op, zero delay.
        single(0, 2'd0, 32'hDEADBEEF, 4'd0, 0);

        // Two continuous requesters alternate from a fresh reset.
        pulse_rst();
        m_mode = 0;
        set_port(0, 2'd1, 32'h11, 4'd2);
        set_port(1, 2'd2, 32'h22, 4'd2);
        base = gnt_cnt;
        req_i = 2'b11;
        wait_cnt("wait_alt_gnt", 0, base + 4, 80);
        req_i = '0;
        wait_cnt("wait_alt_rsp", 1, rsp_cnt + 1, 40);
        wait_cnt("wait_alt_idle", 1, base + 4 + (rsp_cnt - gnt_cnt), 40);
        for (int i = 0; i < 4; i++) chk("alt_order", gnt_log[base + i], alt_exp[i]);

        // Timeout with ready never arriving, then ready on the final WAIT cycle.
        single(1, 2'd3, 32'h12345678, 4'd5, 2);
        single(0, 2'd1, 32'h0BADF00D, 4'd0, 3);

        // Spurious ready while idle: nothing moves, held data stays.
        efpga_ready_i  = 1'b1;
        efpga_result_i = 32'hFFFFFFFF;
        repeat (2) begin
            @(negedge clk);
            chk("spur_idle_busy", busy_o, 0);
            chk("spur_idle_data", rsp_data_o, 32'hA5A5A5A5);
        end
        @(posedge clk); #1;
        efpga_ready_i  = 1'b0;
        efpga_result_i = '0;

        // Spurious ready during ISSUE is ignored.
        single(0, 2'd2, 32'h5555AAAA, 4'd3, 1);

        // Reset in the middle of WAIT drops the op without a response.
        m_mode = 0;
        set_port(1, 2'd3, 32'hCAFEF00D, 4'd15);
        req_i[1] = 1'b1;
        wait_cnt("wait_gnt_rst", 0, gnt_cnt + 1, 20);
        req_i = '0;
        saved = rsp_cnt;
        repeat (4) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("midrst_busy", busy_o, 0);
        chk("midrst_gnt", gnt_o, 0);
        chk("midrst_rsp_valid", rsp_valid_o, 0);
        chk("midrst_rsp_data", rsp_data_o, 0);
        chk("midrst_rsp_err", rsp_err_o, 0);
        chk("midrst_en", efpga_en_o, 0);
        chk("midrst_op", efpga_op_o, 0);
        chk("midrst_operand", efpga_operand_o, 0);
        chk("midrst_delay", efpga_delay_o, 0);
        repeat (20) @(posedge clk);
        #1;
        chk("midrst_no_rsp", rsp_cnt, saved);

        // After reset port 0 has priority when both request.
        m_mode = 0;
        set_port(0, 2'd1, 32'h01020304, 4'd1);
        set_port(1, 2'd2, 32'h0A0B0C0D, 4'd1);
        base = gnt_cnt;
        req_i = 2'b11;
        wait_cnt("wait_gnt_post", 0, base + 1, 20);
        req_i = '0;
        chk("post_rst_owner", gnt_log[base], 0);
        wait_cnt("wait_rsp_post", 1, saved + 1, 40);

        repeat (3) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1);
    end

endmodule

// File: doc/ibex_efpga_arbiter.md
Name: ibex_efpga_arbiter

Overview:
- Round-robin arbiter and sequencer that shares the single eFPGA custom-instruction unit between NUM_REQ requesters (e.g. the ID/EX custom-instruction path and a coprocessor/debug port).
- Accepts one request at a time and latches its operator, operand and delay.
- Drives the eFPGA enable handshake and waits for the unit's ready pulse, with a timeout guard.
- Returns the result (or a timeout error) to the owning requester as a one-cycle response pulse.

Parameters:
- NUM_REQ, 2, number of requesters (2..8).
- TIMEOUT, 32, maximum number of cycles spent in WAIT before aborting (>=2).

Ports:
- clk  in  1  clock; all logic on the rising edge.
- rst  in  1  reset; synchronous, active-high.
- req_i  in  NUM_REQ  per-requester request level.
- req_op_i  in  2*NUM_REQ  operator for requester k at bits [2k+1:2k].
- req_operand_i  in  32*NUM_REQ  operand for requester k at bits [32k+31:32k].
- req_delay_i  in  4*NUM_REQ  eFPGA delay for requester k at bits [4k+3:4k].
- gnt_o  out  NUM_REQ  one-hot acceptance pulse.
- rsp_valid_o  out  NUM_REQ  one-hot response pulse.
- rsp_data_o  out  32  result, shared by all requesters, valid when any rsp_valid_o bit is set.
- rsp_err_o  out  1  timeout flag, qualified by rsp_valid_o.
- busy_o  out  1  high in any state other than IDLE.
- efpga_en_o  out  1  start pulse to the eFPGA unit.
- efpga_op_o  out  2  latched operator.
- efpga_operand_o  out  32  latched operand, presented as the eFPGA result_a input.
- efpga_delay_o  out  4  latched delay.
- efpga_ready_i  in  1  eFPGA completion pulse.
- efpga_result_i  in  32  eFPGA result, valid while efpga_ready_i is high.

Behaviour:
- FSM states: IDLE, ISSUE, WAIT, RESP.
- Reset (rst=1 at an edge, including mid-operation) forces:
  - state IDLE, owner 0, last_owner NUM_REQ-1, timeout counter 0;
  - latched op, operand, delay, result and err all cleared to 0.
  - All outputs are therefore 0 after reset.
  - Any in-flight operation is dropped with no response.
- IDLE:
  - req_i is sampled only in this state.
  - If req_i is nonzero, the winner is the first set bit searching upward from (last_owner+1) mod NUM_REQ, with wrap-around.
  - At that edge: latch the winner's op, operand and delay; set owner to the winner; go to ISSUE.
  - If req_i is zero, stay in IDLE.
- ISSUE (exactly 1 cycle):
  - gnt_o[owner]=1 and efpga_en_o=1.
  - Clear the counter; go to WAIT.
  - The requester must drop req_i after gnt, otherwise it is treated as a new request in a later IDLE.
- WAIT:
  - If efpga_ready_i=1: capture efpga_result_i, set err=0, go to RESP.
  - Else if counter==TIMEOUT-1: set result=0, err=1, go to RESP.
  - Else increment the counter.
  - If ready arrives in the same cycle the limit is reached, ready wins and err=0.
  - WAIT therefore lasts at most TIMEOUT cycles.
- RESP (exactly 1 cycle):
  - rsp_valid_o[owner]=1; rsp_data_o and rsp_err_o come from registers.
  - Set last_owner to owner; go to IDLE.
- Outside RESP, rsp_data_o and rsp_err_o hold their last values; consumers qualify them with rsp_valid_o.
- efpga_op_o, efpga_operand_o and efpga_delay_o are driven from latched registers and are stable from ISSUE through RESP.
- efpga_ready_i outside WAIT is ignored. This includes a late ready after a timeout.
- Latency:
  - Request sampled in IDLE at cycle 0 gives gnt and en at cycle 1.
  - With the eFPGA unit, delay d gives ready at cycle 3+d and rsp_valid at cycle 4+d.
  - Back-to-back throughput is one op per (d+5) cycles, since IDLE costs 1 cycle between ops.
- Fairness: a continuously requesting port cannot win twice in a row while another port is requesting.

Test Plan:
- Reset then req_i=01, op=0, operand=0xDEADBEEF, delay=0:
  - gnt_o=01 and efpga_en_o=1 at cycle 1; ready at cycle 3;
  - rsp_valid_o=01, rsp_data_o=0xDEADBEEF, rsp_err_o=0 at cycle 4.
- Both ports requesting continuously, delay=2, operands 0x11/0x22:
  - grants alternate 01,10,01,10 with last_owner starting at NUM_REQ-1;
  - each rsp_data_o matches the owner's operand.
- eFPGA ready tied 0, TIMEOUT=32:
  - rsp_valid after exactly 32 WAIT cycles;
  - rsp_err_o=1, rsp_data_o=0, busy_o=0 on the next cycle.
- Ready asserted on the final WAIT cycle (counter==TIMEOUT-1) with result 0xA5A5A5A5 -> rsp_err_o=0, data 0xA5A5A5A5.
- rst=1 during WAIT with delay=15 -> next cycle state IDLE, busy_o=0, all outputs 0, no rsp_valid; the following req is served normally with port 0 priority.
- Spurious efpga_ready_i pulses in IDLE and ISSUE -> no state change, no rsp_valid_o.
